// File: rtl/digit_scan.sv
// Four-digit multiplexed display scanner: one active digit per refresh period, inputs shadowed per frame.
// Optional flashing of selected digits is compiled in with `define DIGIT_SCAN_BLINK_EN.
module digit_scan #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits,
  input  logic [3:0]  blank_mask,
  input  logic [3:0]  blink_mask,
  input  logic        colon_in,
  output logic [3:0]  digit_out,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_tick,
  output logic [1:0]  scan_state
);

  typedef enum logic [1:0] {SCAN0 = 2'd0, SCAN1 = 2'd1, SCAN2 = 2'd2, SCAN3 = 2'd3} state_t;

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(REFRESH_DIV - 1);

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic          primed;
  logic [15:0]   digits_sh, digits_sh_nxt;
  logic [3:0]    blank_sh, blank_sh_nxt;
  logic          colon_sh, colon_sh_nxt;
  logic          step, wrap, frame_start;
  logic [1:0]    idx;
  logic [3:0]    dark_mask;
  logic          dark;
  logic [3:0]    digit_out_nxt, an_nxt;
  logic          dp_nxt;

  // The first edge after reset behaves like a frame wrap so digit 0 appears at once.
  assign step        = primed && (presc == TERM);
  assign wrap        = step && (state == SCAN3);
  assign frame_start = !primed || wrap;
  assign scan_state  = state;

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    if (!primed) begin
      presc_nxt = '0;
    end else if (step) begin
      presc_nxt = '0;
      case (state)
        SCAN0:   state_nxt = SCAN1;
        SCAN1:   state_nxt = SCAN2;
        SCAN2:   state_nxt = SCAN3;
        default: state_nxt = SCAN0;
      endcase
    end else begin
      presc_nxt = presc + PW'(1);
    end
  end

  always_comb begin
    digits_sh_nxt = digits_sh;
    blank_sh_nxt  = blank_sh;
    colon_sh_nxt  = colon_sh;
    if (frame_start) begin
      digits_sh_nxt = digits;
      blank_sh_nxt  = blank_mask;
      colon_sh_nxt  = colon_in;
    end
  end

`ifdef DIGIT_SCAN_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_TERM = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt, blink_cnt_nxt;
  logic          blink_phase, blink_phase_nxt;

  // Counting completed frames keeps the lit and dark runs equal from reset onward.
  always_comb begin
    blink_cnt_nxt   = blink_cnt;
    blink_phase_nxt = blink_phase;
    if (wrap) begin
      if (blink_cnt == BLINK_TERM) begin
        blink_cnt_nxt   = '0;
        blink_phase_nxt = !blink_phase;
      end else begin
        blink_cnt_nxt = blink_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      blink_cnt   <= blink_cnt_nxt;
      blink_phase <= blink_phase_nxt;
    end
  end

  assign dark_mask = blank_sh_nxt | (blink_phase_nxt ? blink_mask : 4'b0000);
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask;
  assign dark_mask    = blank_sh_nxt;
`endif

  // Outputs are computed from next-cycle values so they land together with the state change.
  always_comb begin
    idx           = state_nxt;
    dark          = dark_mask[idx];
    digit_out_nxt = digits_sh_nxt[{idx, 2'b00} +: 4];
    an_nxt        = dark ? 4'b1111 : ~(4'b0001 << idx);
    dp_nxt        = !((state_nxt == SCAN2) && colon_sh_nxt && !dark);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SCAN0;
      presc      <= '0;
      primed     <= 1'b0;
      digits_sh  <= '0;
      blank_sh   <= '0;
      colon_sh   <= 1'b0;
      digit_out  <= 4'h0;
      an         <= 4'b1111;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      presc      <= presc_nxt;
      primed     <= 1'b1;
      digits_sh  <= digits_sh_nxt;
      blank_sh   <= blank_sh_nxt;
      colon_sh   <= colon_sh_nxt;
      digit_out  <= digit_out_nxt;
      an         <= an_nxt;
      dp         <= dp_nxt;
      frame_tick <= frame_start;
    end
  end

endmodule

// File: tb/tb_digit_scan.sv
// Directed bench for digit_scan: a REFRESH_DIV=4 instance for scanning, shadowing, blanking, blink and
// reset, plus a REFRESH_DIV=1 instance for the one-cycle-per-digit case.
module tb_digit_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst1_n = 1'b0;
  logic [15:0] digits = 16'h1234;
  logic [3:0]  blank_mask = 4'b0000;
  logic [3:0]  blink_mask = 4'b0000;
  logic        colon_in = 1'b0;

  logic [3:0] digit_out, an, digit_out1, an1;
  logic       dp, frame_tick, dp1, frame_tick1;
  logic [1:0] scan_state, scan_state1;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef DIGIT_SCAN_BLINK_EN
  localparam logic [3:0] BLINK_DARK = 4'b0011;
`else
  localparam logic [3:0] BLINK_DARK = 4'b0000;
`endif

  always #5 clk = ~clk;

  digit_scan #(.REFRESH_DIV(4), .BLINK_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .digits(digits), .blank_mask(blank_mask),
    .blink_mask(blink_mask), .colon_in(colon_in), .digit_out(digit_out),
    .an(an), .dp(dp), .frame_tick(frame_tick), .scan_state(scan_state)
  );

  digit_scan #(.REFRESH_DIV(1), .BLINK_DIV(2)) dut1 (
    .clk(clk), .rst_n(rst1_n), .digits(digits), .blank_mask(blank_mask),
    .blink_mask(blink_mask), .colon_in(colon_in), .digit_out(digit_out1),
    .an(an1), .dp(dp1), .frame_tick(frame_tick1), .scan_state(scan_state1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " an"}, 32'(an), 32'hF);
    check({tag, " digit"}, 32'(digit_out), 32'h0);
    check({tag, " dp"}, 32'(dp), 32'h1);
    check({tag, " tick"}, 32'(frame_tick), 32'h0);
    check({tag, " state"}, 32'(scan_state), 32'h0);
  endtask

  // Samples one whole frame of the REFRESH_DIV=4 instance, starting just after its frame-start edge.
  // Leaves the bench at the sample point of the frame's last cycle so inputs can change before the wrap.
  task automatic check_frame(input string tag, input logic [15:0] exp_dig, input logic [3:0] exp_dark,
                             input logic exp_colon, input int chg_at, input logic [15:0] chg_dig);
    logic [3:0] e_an;
    logic       e_dp;
    for (int c = 0; c < 16; c++) begin
      int k;
      k    = c / 4;
      e_an = exp_dark[k] ? 4'b1111 : ~(4'b0001 << k);
      e_dp = !(k == 2 && exp_colon && !exp_dark[2]);
      check({tag, " an"}, 32'(an), 32'(e_an));
      check({tag, " digit"}, 32'(digit_out), 32'(exp_dig[k*4 +: 4]));
      check({tag, " dp"}, 32'(dp), 32'(e_dp));
      check({tag, " tick"}, 32'(frame_tick), 32'(c == 0));
      check({tag, " state"}, 32'(scan_state), 32'(k));
      if (c == chg_at) digits = chg_dig;
      if (c < 15) @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    check_frame("f1 walk", 16'h1234, 4'b0000, 1'b0, -1, 16'h0);
    @(negedge clk);
    check_frame("f2 shadow", 16'h1234, 4'b0000, 1'b0, 4, 16'h5678);
    @(negedge clk);
    check_frame("f3 new", 16'h5678, 4'b0000, 1'b0, -1, 16'h0);
    blank_mask = 4'b1000;
    colon_in   = 1'b1;
    blink_mask = 4'b0011;
    @(negedge clk);
    check_frame("f4 blink", 16'h5678, 4'b1000 | BLINK_DARK, 1'b1, -1, 16'h0);
    @(negedge clk);
    check_frame("f5 lit", 16'h5678, 4'b1000, 1'b1, -1, 16'h0);
    @(negedge clk);
    check_frame("f6 lit", 16'h5678, 4'b1000, 1'b1, -1, 16'h0);
    @(negedge clk);
    check_frame("f7 blink", 16'h5678, 4'b1000 | BLINK_DARK, 1'b1, -1, 16'h0);
    @(negedge clk);
    check_frame("f8 blink", 16'h5678, 4'b1000 | BLINK_DARK, 1'b1, -1, 16'h0);

    // Walk into SCAN2 of the next frame, then reset between edges.
    repeat (9) @(negedge clk);
    check("pre-reset state", 32'(scan_state), 32'h2);
    #2 rst_n = 1'b0;
    #1 check_reset("async reset");
    @(negedge clk);
    check_reset("held reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_frame("post reset", 16'h5678, 4'b1000, 1'b1, -1, 16'h0);

    blank_mask = 4'b0000;
    blink_mask = 4'b0000;
    colon_in   = 1'b0;
    check("div1 reset an", 32'(an1), 32'hF);
    check("div1 reset tick", 32'(frame_tick1), 32'h0);
    @(negedge clk);
    rst1_n = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 12; c++) begin
      int k;
      k = c % 4;
      check("div1 an", 32'(an1), 32'(~(4'b0001 << k) & 4'hF));
      check("div1 digit", 32'(digit_out1), 32'(4'd8 - 4'(k)));
      check("div1 tick", 32'(frame_tick1), 32'(k == 0));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
